// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, error codes
// and the default memory size that the instruction memory also uses.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } loader_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    localparam int unsigned MEM_BYTES_DEFAULT = 4096;

    // Payload size in bytes for a word count; widened so 0xFFFF words cannot wrap.
    function automatic logic [31:0] frame_bytes(input logic [15:0] words);
        return {14'd0, words, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the big-endian instruction memory: parses
// LEN_HI/LEN_LO/payload/XOR-checksum and holds the CPU in reset while loading.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       words_loaded
);

    localparam logic [31:0] CAPACITY = 32'(MEM_BYTES - BASE_ADDR);

    // Handshake: a byte moves on a rising edge where in_valid & in_ready are both
    // high; in_ready depends on state only, never on in_valid.
    loader_state_t state, state_nxt;

    logic [15:0] len_n;
    logic [17:0] idx;
    logic [7:0]  xor_acc;
    logic [15:0] len_full;
    logic        accept;
    logic        len_over;
    logic        last_byte;
    logic        csum_ok;

    assign in_ready  = state inside {S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK};
    assign accept    = in_valid & in_ready;
    assign len_full  = {len_n[15:8], in_data};
    assign len_over  = frame_bytes(len_full) > CAPACITY;
    assign last_byte = idx == ({len_n, 2'b00} - 18'd1);
    assign csum_ok   = in_data == xor_acc;
    assign cpu_hold  = state != S_IDLE;
    assign done      = state == S_DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (load_start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_over)              state_nxt = S_ERR;
                    else if (len_full == '0)   state_nxt = S_CHECK;
                    else                       state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept && last_byte) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (accept) state_nxt = csum_ok ? S_DONE : S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The write is registered at the accepting edge, so it lands one cycle later,
    // still inside the hold window even for the final payload byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            len_n        <= '0;
            idx          <= '0;
            xor_acc      <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        err          <= 1'b0;
                        err_code     <= ERR_NONE;
                        words_loaded <= '0;
                        idx          <= '0;
                        xor_acc      <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) len_n[15:8] <= in_data;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_n[7:0] <= in_data;
                        if (len_over) begin
                            err      <= 1'b1;
                            err_code <= ERR_LEN;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
                        wr_data <= in_data;
                        idx     <= idx + 18'd1;
                        xor_acc <= xor_acc ^ in_data;
                        if (idx[1:0] == 2'b11) words_loaded <= words_loaded + 16'd1;
                    end
                end
                S_CHECK: begin
                    if (accept && !csum_ok) begin
                        err      <= 1'b1;
                        err_code <= ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of framed loads plus hand-written
// reset-mid-payload and capacity-boundary sequences.
module tb_imem_loader;

    localparam int W = 56;

    typedef struct {
        int         start;
        int         len;
        bit         gap;
        bit         busy_start;
        int         exp_wr;
        bit         exp_done;
        bit         exp_err;
        logic [1:0] exp_code;
        logic [15:0] exp_words;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [7:0]   pool[$];
    vec_t         vecs[$];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;

    wire [62:0] all_outs = {in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, err_code, words_loaded};

    imem_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .words_loaded(words_loaded)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write and done monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (wr_en) obs_q.push_back({cyc[15:0], wr_addr, wr_data});
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic add_vec(input int len, input bit gap, input bit busy, input int nwr,
                           input bit d, input bit e, input logic [1:0] code, input logic [15:0] words);
        vec_t v;
        v.start      = pool.size() - len;
        v.len        = len;
        v.gap        = gap;
        v.busy_start = busy;
        v.exp_wr     = nwr;
        v.exp_done   = d;
        v.exp_err    = e;
        v.exp_code   = code;
        v.exp_words  = words;
        vecs.push_back(v);
    endtask

    // Driver: present one byte, wait (bounded) for acceptance, return at the
    // falling edge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output bit ok, output logic [15:0] wcyc);
        ok = 1'b0;
        wcyc = '0;
        in_valid = 1'b1;
        in_data = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (in_ready) begin
                ok = 1'b1;
                wcyc = 16'(cyc + 1);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: byte 0x%0h not accepted within 20 cycles", b);
        end
    endtask

    task automatic compare_writes(input string name, input int base);
        check({name, "_wr_count"}, 64'(obs_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
            check($sformatf("%s_wr%0d", name, i), 64'(obs_q[base + i]), 64'(exp_q[i]));
    endtask

    task automatic start_session(input string name);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check({name, "_start"}, 64'({cpu_hold, in_ready, err, err_code, words_loaded}),
              64'({1'b1, 1'b1, 1'b0, 2'b00, 16'h0000}));
    endtask

    task automatic run_frame(input string name, input vec_t v);
        bit ok;
        logic [15:0] wcyc;
        logic [7:0] b;
        int base;
        int done_base;
        exp_q.delete();
        base = obs_q.size();
        done_base = done_cnt;
        start_session(name);
        for (int i = 0; i < v.len; i++) begin
            if (v.gap && i > 0) repeat (2) @(negedge clk);
            b = pool[v.start + i];
            send_byte(b, ok, wcyc);
            if (!ok) return;
            if (i >= 2 && i - 2 < v.exp_wr) exp_q.push_back({wcyc, 32'(i - 2), b});
            if (v.busy_start && i == 0) begin
                load_start = 1'b1;
                @(negedge clk);
                load_start = 1'b0;
            end
        end
        check({name, "_final"}, 64'({done, err, cpu_hold, in_ready}), 64'({v.exp_done, v.exp_err, 1'b1, 1'b0}));
        @(negedge clk);
        check({name, "_release"}, 64'({done, cpu_hold, in_ready}), 64'(3'b000));
        check({name, "_err"}, 64'({err, err_code}), 64'({v.exp_err, v.exp_code}));
        check({name, "_words"}, 64'(words_loaded), 64'(v.exp_words));
        check({name, "_done_pulses"}, 64'(done_cnt - done_base), 64'(v.exp_done));
        compare_writes(name, base);
    endtask

    initial begin
        bit ok;
        logic [15:0] wcyc;
        int base;
        logic [7:0] rst_bytes[3];

        rst_n = 1'b0;
        load_start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;

        // Table: frame bytes go into the pool, then the record that describes them.
        pool = {pool, 8'h00, 8'h01, 8'h3C, 8'h0B, 8'h00, 8'h01, 8'h36};
        add_vec(7, 0, 0, 4, 1, 0, 2'b00, 16'd1);
        pool = {pool, 8'h00, 8'h02, 8'h8C, 8'h64, 8'h00, 8'h00, 8'h8C, 8'h65, 8'h00, 8'h04, 8'h05};
        add_vec(11, 0, 0, 8, 1, 0, 2'b00, 16'd2);
        pool = {pool, 8'h00, 8'h02, 8'h8C, 8'h64, 8'h00, 8'h00, 8'h8C, 8'h65, 8'h00, 8'h04, 8'h06};
        add_vec(11, 0, 0, 8, 0, 1, 2'b10, 16'd2);
        pool = {pool, 8'h04, 8'h01};
        add_vec(2, 0, 0, 0, 0, 1, 2'b01, 16'd0);
        pool = {pool, 8'h00, 8'h02, 8'h8C, 8'h64, 8'h00, 8'h00, 8'h8C, 8'h65, 8'h00, 8'h04, 8'h05};
        add_vec(11, 1, 0, 8, 1, 0, 2'b00, 16'd2);
        pool = {pool, 8'h40, 8'h00};
        add_vec(2, 0, 0, 0, 0, 1, 2'b01, 16'd0);
        pool = {pool, 8'h00, 8'h00, 8'h00};
        add_vec(3, 0, 1, 0, 1, 0, 2'b00, 16'd0);

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(all_outs), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", 64'({in_ready, cpu_hold}), 64'(2'b00));

        // Exact-capacity length (1024 words) is accepted; reset after 3 payload bytes.
        exp_q.delete();
        base = obs_q.size();
        start_session("rst");
        send_byte(8'h04, ok, wcyc);
        send_byte(8'h00, ok, wcyc);
        check("rst_cap_fit", 64'({err, in_ready, cpu_hold}), 64'(3'b011));
        rst_bytes[0] = 8'h11;
        rst_bytes[1] = 8'h22;
        rst_bytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            send_byte(rst_bytes[i], ok, wcyc);
            if (ok) exp_q.push_back({wcyc, 32'(i), rst_bytes[i]});
        end
        #1 rst_n = 1'b0;
        #1 check("rst_mid_payload", 64'(all_outs), 64'd0);
        compare_writes("rst", base);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < vecs.size(); k++)
            run_frame($sformatf("vec%0d", k), vecs[k]);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressed, big-endian instruction memory: takes a framed byte stream over a valid/ready handshake and emits byte writes into instruction memory.
- Holds the processor in reset (cpu_hold) while loading, then signals done.
- Sits between the host/debug byte source and the instruction-memory write port.

Parameters:
- MEM_BYTES, 4096, instruction memory size in bytes.
- BASE_ADDR, 0, byte address of the first payload byte; must be a multiple of 4.
- ADDR_W, 32, width of wr_addr; matches the processor read_address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle request to begin a load session.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  byte write strobe to instruction memory.
- wr_addr  out  ADDR_W  byte address of the write.
- wr_data  out  8  byte to write.
- cpu_hold  out  1  high while a session is active; processor is held in reset.
- done  out  1  one-cycle pulse on a successful load.
- err  out  1  sticky error flag, cleared by the next accepted load_start.
- err_code  out  2  01 = length overflow, 10 = checksum mismatch, 00 = none.
- words_loaded  out  16  count of complete 4-byte words written in the current or last session.

Behaviour:
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N*4 payload bytes, big-endian per word: the MSB goes to the lowest address.
  - One checksum byte: XOR of all payload bytes.
- Handshake: a byte transfers on a rising edge with in_valid & in_ready. in_ready is combinational from state only: high in LEN_HI, LEN_LO, PAYLOAD, CHECK; low otherwise.
- States:
  - IDLE: load_start -> LEN_HI. On entry, clears err/err_code, byte index, running XOR and words_loaded.
  - LEN_HI: accept -> latch N[15:8]; -> LEN_LO.
  - LEN_LO: accept -> latch N[7:0], then check capacity:
    - if N*4 > MEM_BYTES - BASE_ADDR (computed ≥18 bits, no truncation) -> ERR with err_code 01;
    - else if N == 0 -> CHECK;
    - else -> PAYLOAD.
  - PAYLOAD: each accepted byte:
    - registers wr_en=1, wr_addr=BASE_ADDR+idx, wr_data=in_data on the next edge (write latency 1 cycle after acceptance);
    - idx increments and the running XOR updates;
    - every 4th byte increments words_loaded;
    - after byte idx == N*4-1 -> CHECK.
  - CHECK: accept -> if byte == running XOR -> DONE, else ERR with err_code 10.
  - DONE: done=1 for exactly one cycle; -> IDLE.
  - ERR: err=1 (sticky); -> IDLE. No done pulse.
- wr_en is low in every cycle without an accepted payload byte. Gaps in in_valid produce no writes and no address advance.
- cpu_hold is high in all states except IDLE. It drops the cycle DONE/ERR returns to IDLE, so the final payload write (at t+1) always completes before release.
- load_start is ignored outside IDLE. in_valid in IDLE is ignored, with in_ready low.
- Already-written bytes are not rolled back on error.
- Reset (async, any time, including mid-payload): state IDLE, all outputs 0 (in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, err_code, words_loaded). The next session restarts at BASE_ADDR.

Decomposition:
- Shared package/header holds:
  - state encoding (IDLE, LEN_HI, LEN_LO, PAYLOAD, CHECK, DONE, ERR);
  - err_code constants ERR_NONE, ERR_LEN, ERR_CSUM;
  - MEM_BYTES default, shared with the instruction memory.
- No sub-module is needed. FSM, counters and XOR accumulator all live in imem_loader.

Test Plan:
- Two-word load: load_start; bytes 00 02 8C 64 00 00 8C 65 00 04 05, in_valid held high -> writes addr 0..7 with 8C,64,00,00,8C,65,00,04, each one cycle after acceptance; words_loaded=2; done pulses once; cpu_hold falls after done; err=0.
- Checksum error: same frame with last byte 06 -> all 8 writes occur, err=1, err_code=10, no done, cpu_hold returns low.
- Length overflow: bytes 04 01 (N=1025, 4100 > 4096) -> no writes, err_code=01, in_ready low the next cycle, FSM IDLE.
- Backpressure gaps: two-word frame with in_valid toggling 1,0,0,1… -> writes only on accepted bytes; addresses contiguous 0..7; same final memory contents and done.
- Reset mid-payload: assert rst_n=0 after 3 payload bytes -> all outputs 0 immediately. After release, a new one-word frame 00 01 3C 0B 00 01 36 writes addr 0..3 and pulses done.
- Zero-length: load_start; bytes 00 00 00 -> no writes, words_loaded=0, done pulses; load_start while busy is ignored.
